// File: rtl/m_ext_pkg.sv
// Shared definitions for the RV32M execute-stage sequencer.
package m_ext_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ALU_MUL    = 5'b01011;
  localparam logic [4:0] ALU_MULH   = 5'b01100;
  localparam logic [4:0] ALU_MULHSU = 5'b01101;
  localparam logic [4:0] ALU_MULHU  = 5'b01110;
  localparam logic [4:0] ALU_DIV    = 5'b01111;
  localparam logic [4:0] ALU_DIVU   = 5'b10000;
  localparam logic [4:0] ALU_REM    = 5'b10001;
  localparam logic [4:0] ALU_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    MOP_MUL    = 2'b00,
    MOP_MULH   = 2'b01,
    MOP_MULHSU = 2'b10,
    MOP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    DOP_DIV  = 2'b00,
    DOP_DIVU = 2'b01,
    DOP_REM  = 2'b10,
    DOP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_BUSY = 2'b01,
    S_DIV_BUSY = 2'b10,
    S_DONE     = 2'b11
  } m_state_t;

  // True for any opcode handled by the M unit.
  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/m_div_special.sv
// Detects divide-by-zero and signed overflow, and forms the architectural
// result for those cases so the divider never has to be started.
module m_div_special #(
  parameter int unsigned XLEN = m_ext_pkg::XLEN
) (
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] result
);
  import m_ext_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic b_zero;
  logic is_rem;
  logic is_signed;
  logic ovf;

  // Classify operands and pick the shortcut result.
  always_comb begin
    b_zero    = (b == '0);
    is_rem    = (div_opcode == DOP_REM) || (div_opcode == DOP_REMU);
    is_signed = (div_opcode == DOP_DIV) || (div_opcode == DOP_REM);
    ovf       = is_signed && (a == MIN_NEG) && (b == '1);
    special   = b_zero || ovf;
    result    = '0;
    if (b_zero) begin
      result = is_rem ? a : '1;
    end else if (ovf) begin
      result = is_rem ? '0 : MIN_NEG;
    end
  end

endmodule

// File: rtl/m_ext_sequencer.sv
// Execute-stage controller for the RV32M multiplier/divider: decodes the op,
// latches operands, starts the unit, stalls the pipeline and returns the result.
module m_ext_sequencer #(
  parameter int unsigned XLEN    = m_ext_pkg::XLEN,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            flushE,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            mul_done,
  input  logic [XLEN-1:0] result_multiply,
  input  logic            div_done,
  input  logic [XLEN-1:0] result_divide,
  output logic            mul_start,
  output logic            div_start,
  output logic            unit_abort,
  output logic [1:0]      mul_opcode,
  output logic [1:0]      div_opcode,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic            stallM,
  output logic            flagM,
  output logic [XLEN-1:0] result_m,
  output logic            timeout_err
);
  import m_ext_pkg::*;

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  m_state_t        state;
  logic            is_m;
  logic            is_mul_op;
  mul_op_t         dec_mop;
  div_op_t         dec_dop;
  logic            div_special;
  logic [XLEN-1:0] div_special_res;
  logic [WDW-1:0]  wd_cnt;

  // Decode the ALU opcode into unit selection and unit-local opcodes.
  always_comb begin
    is_mul_op = 1'b0;
    dec_mop   = MOP_MUL;
    dec_dop   = DOP_DIV;
    case (alu_opE)
      ALU_MUL:    begin is_mul_op = 1'b1; dec_mop = MOP_MUL;    end
      ALU_MULH:   begin is_mul_op = 1'b1; dec_mop = MOP_MULH;   end
      ALU_MULHSU: begin is_mul_op = 1'b1; dec_mop = MOP_MULHSU; end
      ALU_MULHU:  begin is_mul_op = 1'b1; dec_mop = MOP_MULHU;  end
      ALU_DIV:    dec_dop = DOP_DIV;
      ALU_DIVU:   dec_dop = DOP_DIVU;
      ALU_REM:    dec_dop = DOP_REM;
      ALU_REMU:   dec_dop = DOP_REMU;
      default:    ;
    endcase
    is_m = validE && is_m_op(alu_opE);
  end

  m_div_special #(.XLEN(XLEN)) u_div_special (
    .div_opcode (dec_dop),
    .a          (SrcAE),
    .b          (SrcBE),
    .special    (div_special),
    .result     (div_special_res)
  );

  // Stall until DONE; the result is visible for exactly the DONE cycle.
  always_comb begin
    stallM = is_m && !flushE && (state != S_DONE);
    flagM  = (state == S_DONE) && !flushE;
  end

  // Sequencer FSM, operand/opcode latches, watchdog and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      unit_abort  <= 1'b0;
      mul_opcode  <= '0;
      div_opcode  <= '0;
      operand1    <= '0;
      operand2    <= '0;
      result_m    <= '0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      unit_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_m && !flushE) begin
            operand1 <= SrcAE;
            operand2 <= SrcBE;
            wd_cnt   <= '0;
            if (is_mul_op) begin
              mul_opcode <= dec_mop;
              mul_start  <= 1'b1;
              state      <= S_MUL_BUSY;
            end else begin
              div_opcode <= dec_dop;
              if (div_special) begin
                result_m <= div_special_res;
                state    <= S_DONE;
              end else begin
                div_start <= 1'b1;
                state     <= S_DIV_BUSY;
              end
            end
          end
        end
        S_MUL_BUSY, S_DIV_BUSY: begin
          // Flush wins over a same-cycle done; returning to IDLE drops later dones.
          if (flushE) begin
            unit_abort <= 1'b1;
            state      <= S_IDLE;
          end else if ((state == S_MUL_BUSY) && mul_done) begin
            result_m <= result_multiply;
            state    <= S_DONE;
          end else if ((state == S_DIV_BUSY) && div_done) begin
            result_m <= result_divide;
            state    <= S_DONE;
          end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            unit_abort  <= 1'b1;
            timeout_err <= 1'b1;
            result_m    <= '0;
            state       <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_ext_sequencer.sv
// Directed bench for m_ext_sequencer with hand-computed expected values.
module tb_m_ext_sequencer;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_MUL   = 5'b01011;
  localparam logic [4:0] OP_MULHU = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_REM   = 5'b10001;
  localparam logic [4:0] OP_REMU  = 5'b10010;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            validE = 1'b0;
  logic            flushE = 1'b0;
  logic [4:0]      alu_opE = '0;
  logic [XLEN-1:0] SrcAE = '0;
  logic [XLEN-1:0] SrcBE = '0;
  logic            mul_done = 1'b0;
  logic [XLEN-1:0] result_multiply = '0;
  logic            div_done = 1'b0;
  logic [XLEN-1:0] result_divide = '0;
  logic            mul_start;
  logic            div_start;
  logic            unit_abort;
  logic [1:0]      mul_opcode;
  logic [1:0]      div_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            stallM;
  logic            flagM;
  logic [XLEN-1:0] result_m;
  logic            timeout_err;

  int checks = 0;
  int fails  = 0;

  m_ext_sequencer #(.XLEN(XLEN), .TIMEOUT(80)) dut (
    .clk             (clk),
    .rst             (rst),
    .validE          (validE),
    .flushE          (flushE),
    .alu_opE         (alu_opE),
    .SrcAE           (SrcAE),
    .SrcBE           (SrcBE),
    .mul_done        (mul_done),
    .result_multiply (result_multiply),
    .div_done        (div_done),
    .result_divide   (result_divide),
    .mul_start       (mul_start),
    .div_start       (div_start),
    .unit_abort      (unit_abort),
    .mul_opcode      (mul_opcode),
    .div_opcode      (div_opcode),
    .operand1        (operand1),
    .operand2        (operand2),
    .stallM          (stallM),
    .flagM           (flagM),
    .result_m        (result_m),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    validE  = 1'b1;
    alu_opE = op;
    SrcAE   = a;
    SrcBE   = b;
  endtask

  task automatic drop_op();
    validE  = 1'b0;
    flushE  = 1'b0;
    alu_opE = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drop_op();
    tick(); tick();
    #1;
    checks++; if (mul_start !== 1'b0) begin fails++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
    checks++; if (div_start !== 1'b0) begin fails++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
    checks++; if (unit_abort !== 1'b0) begin fails++; $display("FAIL reset_unit_abort: got %b expected 0", unit_abort); end
    checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL reset_stallM: got %b expected 0", stallM); end
    checks++; if (flagM !== 1'b0) begin fails++; $display("FAIL reset_flagM: got %b expected 0", flagM); end
    checks++; if (result_m !== 32'h0) begin fails++; $display("FAIL reset_result_m: got %h expected 0", result_m); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_mul();
    int starts;
    tick();
    drive_op(OP_MUL, 32'd7, 32'd6);
    #1;
    checks++; if (stallM !== 1'b1) begin fails++; $display("FAIL mul_issue_stall: got %b expected 1", stallM); end
    checks++; if (mul_start !== 1'b0) begin fails++; $display("FAIL mul_start_early: got %b expected 0", mul_start); end
    tick();
    checks++; if (mul_start !== 1'b1) begin fails++; $display("FAIL mul_start_pulse: got %b expected 1", mul_start); end
    checks++; if (operand1 !== 32'd7 || operand2 !== 32'd6) begin fails++; $display("FAIL mul_operands: got %h/%h expected 7/6", operand1, operand2); end
    checks++; if (mul_opcode !== 2'b00) begin fails++; $display("FAIL mul_opcode: got %b expected 00", mul_opcode); end
    starts = 1;
    for (int i = 2; i <= 32; i++) begin
      tick();
      if (mul_start === 1'b1) starts++;
      checks++; if (stallM !== 1'b1 || flagM !== 1'b0) begin fails++; $display("FAIL mul_busy_cycle%0d: stall=%b flag=%b expected stall=1 flag=0", i, stallM, flagM); end
    end
    checks++; if (starts !== 1) begin fails++; $display("FAIL mul_start_count: got %0d expected 1", starts); end
    tick();
    mul_done = 1'b1;
    result_multiply = 32'd42;
    #1;
    checks++; if (stallM !== 1'b1) begin fails++; $display("FAIL mul_done_cycle_stall: got %b expected 1", stallM); end
    tick();
    mul_done = 1'b0;
    result_multiply = '0;
    #1;
    checks++; if (flagM !== 1'b1) begin fails++; $display("FAIL mul_flag: got %b expected 1", flagM); end
    checks++; if (result_m !== 32'd42) begin fails++; $display("FAIL mul_result: got %h expected 0000002a", result_m); end
    checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL mul_done_stall: got %b expected 0", stallM); end
    drop_op();
    tick();
    #1;
    checks++; if (flagM !== 1'b0 || mul_start !== 1'b0) begin fails++; $display("FAIL mul_after_done: flag=%b start=%b expected 0/0", flagM, mul_start); end
  endtask

  task automatic test_div_special();
    logic [4:0]      ops  [5] = '{OP_DIVU, OP_REMU, OP_REM, OP_DIV, OP_REM};
    logic [XLEN-1:0] as   [5] = '{32'd100, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000, 32'd7};
    logic [XLEN-1:0] bs   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [XLEN-1:0] exps [5] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h0, 32'h8000_0000, 32'd7};
    logic [1:0]      dops [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_op(ops[i], as[i], bs[i]);
      #1;
      checks++; if (stallM !== 1'b1) begin fails++; $display("FAIL special%0d_stall: got %b expected 1", i, stallM); end
      tick();
      #1;
      checks++; if (flagM !== 1'b1) begin fails++; $display("FAIL special%0d_flag: got %b expected 1", i, flagM); end
      checks++; if (result_m !== exps[i]) begin fails++; $display("FAIL special%0d_result: got %h expected %h", i, result_m, exps[i]); end
      checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL special%0d_done_stall: got %b expected 0", i, stallM); end
      checks++; if (div_start !== 1'b0) begin fails++; $display("FAIL special%0d_div_start: got %b expected 0", i, div_start); end
      checks++; if (div_opcode !== dops[i]) begin fails++; $display("FAIL special%0d_div_opcode: got %b expected %b", i, div_opcode, dops[i]); end
      drop_op();
      tick();
      #1;
      checks++; if (flagM !== 1'b0 || div_start !== 1'b0) begin fails++; $display("FAIL special%0d_after: flag=%b start=%b expected 0/0", i, flagM, div_start); end
    end
  endtask

  task automatic test_flush_idle();
    tick();
    drive_op(OP_MUL, 32'd1, 32'd2);
    flushE = 1'b1;
    #1;
    checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL flush_idle_stall: got %b expected 0", stallM); end
    tick();
    drop_op();
    #1;
    checks++; if (mul_start !== 1'b0 || flagM !== 1'b0) begin fails++; $display("FAIL flush_idle_start: start=%b flag=%b expected 0/0", mul_start, flagM); end
  endtask

  task automatic test_flush_busy();
    tick();
    drive_op(OP_DIV, 32'hFFFF_FFEC, 32'd3);
    tick();
    checks++; if (div_start !== 1'b1) begin fails++; $display("FAIL flush_div_start: got %b expected 1", div_start); end
    checks++; if (div_opcode !== 2'b00 || operand1 !== 32'hFFFF_FFEC) begin fails++; $display("FAIL flush_div_latch: op=%b a=%h expected 00/ffffffec", div_opcode, operand1); end
    for (int i = 2; i <= 5; i++) begin
      tick();
      checks++; if (div_start !== 1'b0 || stallM !== 1'b1) begin fails++; $display("FAIL flush_busy%0d: start=%b stall=%b expected 0/1", i, div_start, stallM); end
    end
    flushE = 1'b1;
    #1;
    checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL flush_busy_stall: got %b expected 0", stallM); end
    tick();
    drop_op();
    div_done = 1'b1;
    result_divide = 32'hFFFF_FFFA;
    #1;
    checks++; if (unit_abort !== 1'b1) begin fails++; $display("FAIL flush_abort: got %b expected 1", unit_abort); end
    checks++; if (flagM !== 1'b0 || stallM !== 1'b0) begin fails++; $display("FAIL flush_no_flag: flag=%b stall=%b expected 0/0", flagM, stallM); end
    tick();
    div_done = 1'b0;
    result_divide = '0;
    #1;
    checks++; if (unit_abort !== 1'b0) begin fails++; $display("FAIL flush_abort_width: got %b expected 0", unit_abort); end
    checks++; if (flagM !== 1'b0) begin fails++; $display("FAIL flush_late_done_flag: got %b expected 0", flagM); end
    tick();
    #1;
    checks++; if (result_m !== 32'd7) begin fails++; $display("FAIL flush_result_kept: got %h expected 00000007", result_m); end
  endtask

  task automatic test_timeout();
    tick();
    drive_op(OP_MULHU, 32'd5, 32'd9);
    tick();
    checks++; if (mul_start !== 1'b1 || mul_opcode !== 2'b11) begin fails++; $display("FAIL to_start: start=%b op=%b expected 1/11", mul_start, mul_opcode); end
    for (int i = 2; i <= 80; i++) begin
      tick();
      checks++; if (unit_abort !== 1'b0 || timeout_err !== 1'b0 || stallM !== 1'b1) begin fails++; $display("FAIL to_busy%0d: abort=%b err=%b stall=%b expected 0/0/1", i, unit_abort, timeout_err, stallM); end
    end
    tick();
    #1;
    checks++; if (unit_abort !== 1'b1) begin fails++; $display("FAIL to_abort: got %b expected 1", unit_abort); end
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b expected 1", timeout_err); end
    checks++; if (flagM !== 1'b1 || result_m !== 32'h0) begin fails++; $display("FAIL to_result: flag=%b res=%h expected 1/00000000", flagM, result_m); end
    drop_op();
    tick();
    #1;
    checks++; if (unit_abort !== 1'b0 || flagM !== 1'b0) begin fails++; $display("FAIL to_after: abort=%b flag=%b expected 0/0", unit_abort, flagM); end
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    tick();
    drive_op(OP_MUL, 32'd3, 32'd5);
    tick();
    tick(); tick(); tick();
    mul_done = 1'b1;
    result_multiply = 32'd15;
    tick();
    mul_done = 1'b0;
    drive_op(OP_DIVU, 32'd100, 32'd7);
    #1;
    checks++; if (flagM !== 1'b1 || result_m !== 32'd15) begin fails++; $display("FAIL b2b_mul: flag=%b res=%h expected 1/0000000f", flagM, result_m); end
    checks++; if (stallM !== 1'b0) begin fails++; $display("FAIL b2b_done_stall: got %b expected 0", stallM); end
    tick();
    #1;
    checks++; if (div_start !== 1'b0 || stallM !== 1'b1) begin fails++; $display("FAIL b2b_idle: start=%b stall=%b expected 0/1", div_start, stallM); end
    tick();
    checks++; if (div_start !== 1'b1 || operand1 !== 32'd100 || operand2 !== 32'd7) begin fails++; $display("FAIL b2b_div_issue: start=%b a=%h b=%h expected 1/64/7", div_start, operand1, operand2); end
    tick(); tick();
    #3;
    rst = 1'b0;
    drop_op();
    #1;
    checks++; if (operand1 !== 32'h0 || operand2 !== 32'h0 || div_opcode !== 2'b00) begin fails++; $display("FAIL async_rst_latch: a=%h b=%h op=%b expected 0/0/00", operand1, operand2, div_opcode); end
    checks++; if (timeout_err !== 1'b0 || result_m !== 32'h0) begin fails++; $display("FAIL async_rst_sticky: err=%b res=%h expected 0/0", timeout_err, result_m); end
    checks++; if (stallM !== 1'b0 || flagM !== 1'b0 || unit_abort !== 1'b0) begin fails++; $display("FAIL async_rst_ctl: stall=%b flag=%b abort=%b expected 0/0/0", stallM, flagM, unit_abort); end
    tick();
    rst = 1'b1;
    tick();
    drive_op(OP_DIVU, 32'd100, 32'd7);
    tick();
    checks++; if (div_start !== 1'b1 || div_opcode !== 2'b01) begin fails++; $display("FAIL reissue_start: start=%b op=%b expected 1/01", div_start, div_opcode); end
    tick(); tick();
    div_done = 1'b1;
    result_divide = 32'd14;
    tick();
    div_done = 1'b0;
    #1;
    checks++; if (flagM !== 1'b1 || result_m !== 32'd14) begin fails++; $display("FAIL reissue_result: flag=%b res=%h expected 1/0000000e", flagM, result_m); end
    drop_op();
    tick();
    #1;
    checks++; if (flagM !== 1'b0 || stallM !== 1'b0) begin fails++; $display("FAIL reissue_after: flag=%b stall=%b expected 0/0", flagM, stallM); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_special();
    test_flush_idle();
    test_flush_busy();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
